mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, TX byte FIFO entries; power of two, 2..256.
REQ-003 Parameter TX_ADDR, default 16'hFFF0, store address that enqueues a byte.
REQ-004 Parameter STAT_ADDR, default 16'hFFF1, address of the status register.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 mem_write_en  input  1  CPU store strobe, valid for one cycle.
REQ-009 mem_write_addr  input  16  CPU store address.
REQ-010 mem_write_data  input  16  CPU store data; bits [7:0] are the payload.
REQ-011 mmio_rd_addr  input  16  CPU data-read address, driven by the CPU's data-port read address.
REQ-012 mmio_rd_hit  output  1  high when mmio_rd_addr == STAT_ADDR (combinational).
REQ-013 mmio_rd_data  output  16  {13'b0, overflow, full, busy} when hit, else 16'h0000 (combinational).
REQ-014 tx  output  1  serial line, idle high.
REQ-015 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy, registered.

Function
REQ-016 A store SHALL push mem_write_data[7:0] when mem_write_en=1, mem_write_addr==TX_ADDR, and the FIFO is not full. All other addresses SHALL be ignored.
REQ-017 A push to a full FIFO SHALL be dropped and SHALL set the sticky overflow bit, unless a pop occurs in the same cycle; in that case the push SHALL be accepted.
REQ-018 A store with mem_write_en=1 to STAT_ADDR SHALL clear overflow, whatever the data. If a drop and a clear happen in the same cycle, the set SHALL win.
REQ-019 full SHALL equal (fifo_level == FIFO_DEPTH). busy SHALL be 1 whenever the FSM is not IDLE or fifo_level != 0.
REQ-020 The serializer FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-021 IDLE: tx=1. If fifo_level != 0 as registered before the edge, the FSM SHALL pop the head into the shift register and go to START. A byte pushed at edge N therefore pops at edge N+1, and tx goes low after edge N+1.
REQ-022 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-023 DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7 the FSM SHALL go to STOP.
REQ-024 STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, the FSM SHALL pop and go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-025 One frame SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit change.
REQ-027 Simultaneous push and pop SHALL leave fifo_level unchanged and keep the data in FIFO order.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated bytes.
REQ-029 tx SHALL be driven from a flop and be glitch-free.

Reset
REQ-030 While rst_n=0, and immediately on assertion (asynchronous): tx=1, FSM=IDLE, fifo_level=0, pointers=0, overflow=0, baud counter=0, bit index=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; tx SHALL return high without completing the stop bit, and all queued bytes SHALL be discarded.
REQ-032 The first push SHALL be honoured on the first rising edge after rst_n deasserts.

Structure
REQ-033 The FSM state encoding, TX_ADDR/STAT_ADDR defaults, and status bit positions SHALL live in the shared package jpeb_mmio_pkg, so the CPU-side address decode uses the same constants.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width 8 and depth; ports push, pop, din, dout, level, full, empty). Serializer and decode SHALL stay in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-035 Single byte: store 16'h0055 to 16'hFFF0 -> tx waveform 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit. tx first goes low one cycle after the push edge. busy=0 after 40 cycles.
REQ-036 Back-to-back: push 8'hA5 then 8'h3C on consecutive cycles -> two frames with no idle cycle between the stop bit and the second start bit, 80 cycles total.
REQ-037 Overflow: push 6 bytes on consecutive cycles while idle -> the first pops at the second edge. The 5th byte is accepted, the 6th is dropped, and overflow=1 (mmio_rd_data=16'h0007 on read). A store to 16'hFFF1 then clears it to 16'h0003.
REQ-038 Wrap: 10 sequential bytes 8'h00..8'h09, each pushed when not full -> tx carries 00..09 in order; fifo_level returns to 0.
REQ-039 Reset mid-frame: pull rst_n low during bit 3 of 8'hFF with 2 bytes queued -> tx=1 within the same cycle, fifo_level=0, and no further frames after release.
REQ-040 Decode: stores to 16'hFFEF and 16'hFFF2, and reads at 16'h0000 -> no push, and mmio_rd_hit=0 with mmio_rd_data=16'h0000.

Source files
------------

// File: rtl/jpeb_mmio_pkg.sv
// rtl/jpeb_mmio_pkg.sv - shared MMIO UART constants, FSM encoding and status layout
package jpeb_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [15:0] UART_TX_ADDR   = 16'hFFF0;
  localparam logic [15:0] UART_STAT_ADDR = 16'hFFF1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  // Status word as seen by the CPU; all other bits read as zero.
  function automatic logic [15:0] status_word(input logic ovf, input logic full, input logic busy);
    logic [15:0] w;
    w = '0;
    w[STAT_OVF_BIT]  = ovf;
    w[STAT_FULL_BIT] = full;
    w[STAT_BUSY_BIT] = busy;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with byte FIFO and status register
module mmio_uart_tx
  import jpeb_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [15:0] STAT_ADDR    = UART_STAT_ADDR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_write_en,
  input  logic [15:0]                   mem_write_addr,
  input  logic [15:0]                   mem_write_data,
  input  logic [15:0]                   mmio_rd_addr,
  output logic                          mmio_rd_hit,
  output logic [15:0]                   mmio_rd_data,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        overflow;

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        tx_wr;
  logic        stat_wr;
  logic        pop;
  logic        baud_done;
  logic        busy;
  logic        unused_data_hi;

  assign unused_data_hi = ^mem_write_data[15:8];

  assign tx_wr     = mem_write_en && (mem_write_addr == TX_ADDR);
  assign stat_wr   = mem_write_en && (mem_write_addr == STAT_ADDR);
  assign baud_done = (baud == BAUD_LAST);

  // The head leaves the FIFO when idle, or at the last stop-bit cycle for a gapless next frame.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

  assign busy         = (state != IDLE) || !fifo_empty;
  assign mmio_rd_hit  = (mmio_rd_addr == STAT_ADDR);
  assign mmio_rd_data = mmio_rd_hit ? status_word(overflow, fifo_full, busy) : 16'h0000;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_wr),
    .pop   (pop),
    .din   (mem_write_data[7:0]),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: a dropped byte sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (tx_wr && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (stat_wr) begin
      overflow <= 1'b0;
    end
  end

  // Serializer: tx is registered and updated together with each state or bit change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state <= START;
            shift <= fifo_dout;
            tx    <= 1'b0;
            baud  <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            tx      <= shift[0];
            baud    <= '0;
            bit_idx <= '0;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (!fifo_empty) begin
              state <= START;
              shift <= fifo_dout;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [15:0] TXA  = 16'hFFF0;
  localparam logic [15:0] STA  = 16'hFFF1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [15:0] mem_write_addr = 16'h0000;
  logic [15:0] mem_write_data = 16'h0000;
  logic [15:0] mmio_rd_addr = STA;
  logic        mmio_rd_hit;
  logic [15:0] mmio_rd_data;
  logic        tx;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  mmio_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D),
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mmio_rd_addr   (mmio_rd_addr),
    .mmio_rd_hit    (mmio_rd_hit),
    .mmio_rd_data   (mmio_rd_data),
    .tx             (tx),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial receiver: samples every cycle of a frame on the falling edge and scores the byte.
  initial begin : monitor
    logic [9:0] bits;
    logic       stable;
    logic       abort;
    logic [7:0] exp_b;
    int         s;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        s = cyc;
        abort = 1'b0;
        stable = 1'b1;
        bits = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < C && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (!abort) begin
          frames++;
          start_q.push_back(s);
          checks++;
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || stable !== 1'b1) begin
            errors++;
            $display("FAIL frame_shape start_cyc=%0d: got start=%b stop=%b stable=%b, want 0 1 1", s, bits[0], bits[9], stable);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame start_cyc=%0d: got byte %h, want no frame", s, bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            if (bits[8:1] !== exp_b) begin
              errors++;
              $display("FAIL frame_data start_cyc=%0d: got %h, want %h", s, bits[8:1], exp_b);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Entered just after a falling edge; returns on the falling edge after the store's rising edge.
  task automatic store(input logic [15:0] addr, input logic [15:0] data, output int edge_cyc);
    mem_write_en   = 1'b1;
    mem_write_addr = addr;
    mem_write_data = data;
    @(negedge clk);
    edge_cyc = cyc;
    mem_write_en   = 1'b0;
    mem_write_addr = 16'h0000;
    mem_write_data = 16'h0000;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mmio_rd_data[0] !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes pending busy=%b after 2000 cycles, want 0 pending busy=0", name, exp_q.size(), mmio_rd_data[0]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++;
    if (mmio_rd_hit !== 1'b1 || mmio_rd_data !== 16'h0000) begin
      errors++; $display("FAIL reset_status: got hit=%b data=%h want hit=1 data=0000", mmio_rd_hit, mmio_rd_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int e;
    start_q.delete();
    store(TXA, 16'h0055, e);
    exp_q.push_back(8'h55);
    while (cyc < e + 40) @(negedge clk);
    checks++;
    if (mmio_rd_data !== 16'h0001) begin errors++; $display("FAIL single_busy_last: got %h want 0001", mmio_rd_data); end
    @(negedge clk);
    checks++;
    if (mmio_rd_data !== 16'h0000) begin errors++; $display("FAIL single_idle: got %h want 0000", mmio_rd_data); end
    checks++;
    if (start_q.size() != 1 || start_q[0] != e + 1) begin
      errors++; $display("FAIL single_latency: got %0d frames first at %0d, want 1 frame at %0d", start_q.size(), start_q[0], e + 1);
    end
  endtask

  task automatic test_back_to_back();
    int e1;
    int e2;
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    store(TXA, 16'h00A5, e1);
    store(TXA, 16'h003C, e2);
    wait_drain("b2b");
    checks++;
    if (start_q.size() != 2 || start_q[0] != e1 + 1 || start_q[1] != e1 + 41) begin
      errors++; $display("FAIL b2b_timing: got %0d frames at %0d,%0d want 2 at %0d,%0d", start_q.size(), start_q[0], start_q[1], e1 + 1, e1 + 41);
    end
  endtask

  task automatic test_overflow();
    int e;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h10 + i));
      store(TXA, 16'(16'h0010 + i), e);
      if (i == 1) begin
        checks++;
        if (fifo_level !== 3'd1) begin errors++; $display("FAIL ovf_first_pop: got level %0d want 1", fifo_level); end
      end
    end
    checks++;
    if (mmio_rd_data !== 16'h0007 || fifo_level !== 3'd4) begin
      errors++; $display("FAIL ovf_set: got status %h level %0d want 0007 level 4", mmio_rd_data, fifo_level);
    end
    store(STA, 16'hFFFF, e);
    checks++;
    if (mmio_rd_data !== 16'h0003) begin errors++; $display("FAIL ovf_clear: got %h want 0003", mmio_rd_data); end
    wait_drain("ovf");
    checks++;
    if (mmio_rd_data !== 16'h0000) begin errors++; $display("FAIL ovf_final: got %h want 0000", mmio_rd_data); end
  endtask

  task automatic test_wrap();
    int e;
    int f0;
    int n;
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (fifo_level == 3'd4 && n < 200) begin @(negedge clk); n++; end
      exp_q.push_back(8'(i));
      store(TXA, 16'(i), e);
    end
    wait_drain("wrap");
    checks++;
    if (fifo_level !== 3'd0 || frames - f0 != 10) begin
      errors++; $display("FAIL wrap_end: got level %0d frames %0d want level 0 frames 10", fifo_level, frames - f0);
    end
  endtask

  task automatic test_decode();
    int e;
    int f0;
    f0 = frames;
    store(16'hFFEF, 16'h0011, e);
    store(16'hFFF2, 16'h0022, e);
    checks++;
    if (fifo_level !== 3'd0 || mmio_rd_data !== 16'h0000) begin
      errors++; $display("FAIL decode_nopush: got level %0d status %h want 0 0000", fifo_level, mmio_rd_data);
    end
    mmio_rd_addr = 16'h0000;
    #1;
    checks++;
    if (mmio_rd_hit !== 1'b0 || mmio_rd_data !== 16'h0000) begin
      errors++; $display("FAIL decode_rd0: got hit=%b data=%h want 0 0000", mmio_rd_hit, mmio_rd_data);
    end
    mmio_rd_addr = TXA;
    #1;
    checks++;
    if (mmio_rd_hit !== 1'b0) begin errors++; $display("FAIL decode_rdtx: got hit=%b want 0", mmio_rd_hit); end
    mmio_rd_addr = STA;
    repeat (50) @(negedge clk);
    checks++;
    if (frames != f0) begin errors++; $display("FAIL decode_frames: got %0d frames want 0", frames - f0); end
  endtask

  task automatic test_reset_mid(input logic [7:0] b);
    int e;
    int e2;
    int f0;
    store(TXA, {8'h00, b}, e);
    store(TXA, 16'h00AA, e2);
    store(TXA, 16'h00BB, e2);
    while (cyc < e + 18) @(negedge clk);
    checks++;
    if (tx !== b[3] || fifo_level !== 3'd2) begin
      errors++; $display("FAIL rstmid_pre_%h: got tx=%b level %0d want tx=%b level 2", b, tx, fifo_level, b[3]);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (tx !== 1'b1 || fifo_level !== 3'd0 || mmio_rd_data !== 16'h0000) begin
      errors++; $display("FAIL rstmid_async_%h: got tx=%b level %0d status %h want 1 0 0000", b, tx, fifo_level, mmio_rd_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    repeat (60) @(negedge clk);
    checks++;
    if (frames != f0 || tx !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL rstmid_after_%h: got frames %0d tx=%b level %0d want 0 1 0", b, frames - f0, tx, fifo_level);
    end
  endtask

  task automatic test_first_push();
    int e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_q.delete();
    exp_q.push_back(8'h81);
    store(TXA, 16'h0081, e);
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL first_push_level: got %0d want 1", fifo_level); end
    wait_drain("first");
    checks++;
    if (start_q.size() != 1 || start_q[0] != e + 1) begin
      errors++; $display("FAIL first_push_start: got %0d frames at %0d want 1 at %0d", start_q.size(), start_q[0], e + 1);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_decode();
    test_reset_mid(8'hFF);
    test_reset_mid(8'h00);
    test_first_push();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d bytes not seen want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
